// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Shared fetch-state encoding, MIPS opcodes and instruction field positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int TIMEOUT_W  = 8;

  // Word offset of a branch immediate, sign-extended to a byte displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module : fetch_unit_if
// Instruction-memory req/ack handshake between the fetch unit and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;

  modport master (
    output Imem_Req,
    output Imem_Addr,
    input  Imem_Ack,
    input  Imem_Data
  );

  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    output Imem_Ack,
    output Imem_Data
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit_next_pc_calc.sv
// ============================================================================
// Module : next_pc_calc
// Combinational next-PC selection: jump, taken branch, or fall-through.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_calc
  import mips_pkg::*;
(
  input  wire  [31:0]                 PC_Plus_4,
  input  wire  [TARGET_MSB:TARGET_LSB] Inst_Fields,
  input  wire                         Branch,
  input  wire                         Branch_Not_Equal,
  input  wire                         Jump,
  input  wire                         Zero,
  output logic [31:0]                 Next_PC
);

  logic        w_taken;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  // Both branch controls together are treated as always taken.
  assign w_taken         = (Branch & Zero) | (Branch_Not_Equal & ~Zero);
  assign w_jump_target   = {PC_Plus_4[31:28], Inst_Fields, 2'b00};
  assign w_branch_target = PC_Plus_4 + branch_offset(Inst_Fields[IMM_MSB:IMM_LSB]);

  always_comb begin
    Next_PC = PC_Plus_4;
    if (Jump)
      Next_PC = w_jump_target;
    else if (w_taken)
      Next_PC = w_branch_target;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// PC owner: fetches over req/ack, issues one instruction, resolves next PC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
)(
  input  wire          clk,
  input  wire          reset_n,
  fetch_unit_if.master imem,
  input  wire          Stall,
  input  wire          Branch,
  input  wire          Branch_Not_Equal,
  input  wire          Jump,
  input  wire          Zero,
  output logic [31:0]  Inst,
  output logic         Inst_Valid,
  output logic [31:0]  PC,
  output logic [31:0]  PC_Plus_4,
  output logic [31:0]  Retired_Count,
  output logic         Fetch_Fault
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(FETCH_TIMEOUT);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  if ((FETCH_TIMEOUT < 1) || (FETCH_TIMEOUT > 255)) begin : g_bad_timeout
    $error("fetch_unit: FETCH_TIMEOUT must be in 1..255");
  end

  fetch_state_e         r_state;
  logic [31:0]          r_pc;
  logic [31:0]          r_inst;
  logic [31:0]          r_retired;
  logic                 r_fault;
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  logic [31:0]          w_pc_plus_4;
  logic [31:0]          w_next_pc;
  logic [TIMEOUT_W-1:0] w_wait_cnt_inc;

  assign w_pc_plus_4    = r_pc + 32'd4;
  assign w_wait_cnt_inc = r_wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  next_pc_calc u_next_pc (
    .PC_Plus_4        (w_pc_plus_4),
    .Inst_Fields      (r_inst[TARGET_MSB:TARGET_LSB]),
    .Branch           (Branch),
    .Branch_Not_Equal (Branch_Not_Equal),
    .Jump             (Jump),
    .Zero             (Zero),
    .Next_PC          (w_next_pc)
  );

  // Ack is only looked at in FETCH, so a late ack from before reset is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_retired  <= '0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.Imem_Ack) begin
            r_inst     <= imem.Imem_Data;
            r_wait_cnt <= '0;
            r_state    <= ST_ISSUE;
          end else begin
            r_wait_cnt <= w_wait_cnt_inc;
            if (w_wait_cnt_inc == TIMEOUT_LIMIT) begin
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end
          end
        end
        ST_ISSUE: begin
          if (!Stall) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
            r_state   <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem.Imem_Req  = (r_state == ST_FETCH);
  assign imem.Imem_Addr = r_pc;

  assign Inst          = r_inst;
  assign Inst_Valid    = (r_state == ST_ISSUE);
  assign PC            = r_pc;
  assign PC_Plus_4     = w_pc_plus_4;
  assign Retired_Count = r_retired;
  assign Fetch_Fault   = r_fault;

endmodule

`default_nettype wire
